// File: rtl/w_prio_pkg.sv
// w_prio_pkg: shared types and helpers for the sequential priority encoder.
//   clog2 - index width for a given number of request lines
//   state_t - arbitration state (IDLE: free to pick, HOLD: index frozen)
//   norm - converts one pin between its pin polarity and active-high
package w_prio_pkg;

    typedef enum logic {IDLE, HOLD} state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    // The conversion is its own inverse, so the same helper serves inputs and outputs.
    function automatic logic norm(input logic x, input bit active_low);
        return x ^ active_low;
    endfunction

endpackage

// File: rtl/w_prio_find.sv
// w_prio_find: combinational highest-set-bit finder.
//   vec_i [WIDTH] - vector to search, bit WIDTH-1 has the highest priority
//   any_o         - at least one bit of vec_i is set
//   idx_o [IDXW]  - index of the highest set bit, 0 when vec_i is empty
module w_prio_find
    import w_prio_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IDXW = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             any_o,
    output logic [IDXW-1:0]  idx_o
);

    // Ascending scan: the last set bit visited wins, giving the highest index.
    always_comb begin
        any_o = |vec_i;
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++)
            if (vec_i[i]) idx_o = IDXW'(i);
    end

endmodule

// File: rtl/w_prio_encoder_seq.sv
// w_prio_encoder_seq: clocked priority encoder with 74HC148-style cascade pins
// and an optional sticky (edge-captured, Ack-cleared) pending mode.
//   clk          - rising-edge clock
//   rst_n        - asynchronous active-low reset
//   EI           - enable input (pin polarity per ACTIVE_LOW)
//   DataIn [W]   - request lines, bit WIDTH-1 highest priority (pin polarity)
//   Ack          - active-high: the reported request has been serviced (sticky only)
//   DataOut [IW] - reported index (pin polarity, inverted when ACTIVE_LOW)
//   GS           - group select: enabled and reporting
//   EO           - enable out: enabled and nothing pending
module w_prio_encoder_seq
    import w_prio_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit STICKY     = 1'b1,
    localparam int IDXW      = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EI,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             Ack,
    output logic [IDXW-1:0]  DataOut,
    output logic             GS,
    output logic             EO
);

    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] clr;
    logic             en, en_q;
    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [IDXW-1:0]  find_idx;
    logic [IDXW-1:0]  out_idx;
    logic             find_any;
    logic             arb;
    logic             rep;
    logic             eo;

    for (genvar g = 0; g < WIDTH; g++) begin : g_req
        assign req[g] = norm(DataIn[g], ACTIVE_LOW);
    end

    assign en = norm(EI, ACTIVE_LOW);

    w_prio_find #(.WIDTH(WIDTH)) u_find (
        .vec_i (pend_q),
        .any_o (find_any),
        .idx_o (find_idx)
    );

    // Sticky mode: OR-ing in new edges after the clear means a fresh edge on
    // the bit being acknowledged keeps it pending.
    always_comb begin
        clr     = (STICKY && state_q == HOLD && Ack && en_q) ? (WIDTH'(1) << idx_q) : '0;
        pend_d  = STICKY ? ((pend_q & ~clr) | (req & ~prev_q)) : req;
        arb     = STICKY && state_q == IDLE && en_q && find_any;
        state_d = !STICKY ? IDLE :
                  (state_q == IDLE) ? (arb ? HOLD : IDLE) :
                  (!en_q || Ack) ? IDLE : HOLD;
        idx_d   = arb ? find_idx : idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            prev_q  <= '0;
            pend_q  <= '0;
            idx_q   <= '0;
            state_q <= IDLE;
        end else begin
            en_q    <= en;
            prev_q  <= req;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    // Outputs come from registers only; level mode reads the finder on the
    // registered request vector so the index appears one cycle after DataIn.
    assign rep     = en_q && (STICKY ? (state_q == HOLD) : find_any);
    assign eo      = en_q && !find_any && !rep;
    assign out_idx = rep ? (STICKY ? idx_q : find_idx) : '0;
    assign GS      = norm(rep, ACTIVE_LOW);
    assign EO      = norm(eo, ACTIVE_LOW);

    for (genvar g = 0; g < IDXW; g++) begin : g_out
        assign DataOut[g] = norm(out_idx[g], ACTIVE_LOW);
    end

endmodule

// File: tb/tb_w_prio_encoder_seq.sv
// tb_w_prio_encoder_seq: directed and randomized checks of the sticky
// active-low 8-line encoder and the level-mode active-high 16-line encoder.
module tb_w_prio_encoder_seq;

    logic       clk;
    logic       rst_n;
    logic       ei;
    logic       ack;
    logic [7:0] din;
    logic [2:0] dout;
    logic       gs;
    logic       eo;

    logic        lv_ei;
    logic        lv_ack;
    logic [15:0] lv_din;
    logic [3:0]  lv_dout;
    logic        lv_gs;
    logic        lv_eo;

    int checks;
    int errors;

    // Reference model of the sticky encoder (active-high view).
    bit       m_en;
    bit       m_hold;
    bit [7:0] m_prev;
    bit [7:0] m_pend;
    int       m_idx;

    // Level-mode reference: inputs seen at the last clock edge.
    bit        lv_en_s;
    bit [15:0] lv_req_s;

    w_prio_encoder_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .EI      (ei),
        .DataIn  (din),
        .Ack     (ack),
        .DataOut (dout),
        .GS      (gs),
        .EO      (eo)
    );

    w_prio_encoder_seq #(.WIDTH(16), .ACTIVE_LOW(1'b0), .STICKY(1'b0)) dut_lvl (
        .clk     (clk),
        .rst_n   (rst_n),
        .EI      (lv_ei),
        .DataIn  (lv_din),
        .Ack     (lv_ack),
        .DataOut (lv_dout),
        .GS      (lv_gs),
        .EO      (lv_eo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int highest8(input bit [7:0] v);
        int h;
        h = -1;
        for (int i = 0; i < 8; i++) if (v[i]) h = i;
        return h;
    endfunction

    function automatic int highest16(input bit [15:0] v);
        int h;
        h = -1;
        for (int i = 0; i < 16; i++) if (v[i]) h = i;
        return h;
    endfunction

    task automatic model_reset();
        m_en = 0; m_hold = 0; m_prev = '0; m_pend = '0; m_idx = 0;
        lv_en_s = 0; lv_req_s = '0;
    endtask

    // One clock edge of the sticky rules applied to the current pins.
    task automatic model_step();
        bit [7:0] r;
        bit [7:0] nxt;
        bit       clr_on;
        r = ~din;
        clr_on = m_hold && ack && m_en;
        for (int i = 0; i < 8; i++)
            nxt[i] = (m_pend[i] && !(clr_on && i == m_idx)) || (r[i] && !m_prev[i]);
        if (!m_hold) begin
            if (m_en && m_pend != 0) begin
                m_hold = 1;
                m_idx = highest8(m_pend);
            end
        end else if (!m_en || ack) begin
            m_hold = 0;
        end
        m_pend = nxt;
        m_prev = r;
        m_en = !ei;
        lv_en_s = lv_ei;
        lv_req_s = lv_din;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ei = 1'b1; din = 8'hFF; ack = 1'b0;
        lv_ei = 1'b0; lv_din = '0; lv_ack = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dout, gs, eo} !== 5'b111_1_1) begin
            errors++; $display("FAIL reset_out got %b exp %b", {dout, gs, eo}, 5'b11111);
        end
        rst_n = 1'b1;
        ei = 1'b0;
        tick(); tick();
        checks++;
        if ({dout, gs, eo} !== 5'b111_1_0) begin
            errors++; $display("FAIL reset_enabled_idle got %b exp %b", {dout, gs, eo}, 5'b11110);
        end
        din = 8'hDF; tick(); din = 8'hFF; tick();
        checks++;
        if ({dout, gs} !== 4'b010_0) begin
            errors++; $display("FAIL reset_hold5 got %b exp %b", {dout, gs}, 4'b0100);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({dout, gs, eo} !== 5'b111_1_1) begin
            errors++; $display("FAIL reset_async got %b exp %b", {dout, gs, eo}, 5'b11111);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sticky_priority();
        do_reset();
        ei = 1'b0; tick();
        din = 8'hBB; tick(); din = 8'hFF; tick();
        checks++;
        if ({dout, gs, eo} !== 5'b001_0_1) begin
            errors++; $display("FAIL prio_first got %b exp %b", {dout, gs, eo}, 5'b00101);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if ({dout, gs, eo} !== 5'b111_1_1) begin
            errors++; $display("FAIL prio_idle got %b exp %b", {dout, gs, eo}, 5'b11111);
        end
        tick();
        checks++;
        if ({dout, gs, eo} !== 5'b101_0_1) begin
            errors++; $display("FAIL prio_second got %b exp %b", {dout, gs, eo}, 5'b10101);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if ({gs, eo} !== 2'b1_0) begin
            errors++; $display("FAIL prio_empty got %b exp %b", {gs, eo}, 2'b10);
        end
    endtask

    task automatic test_hold_freeze();
        do_reset();
        ei = 1'b0; tick();
        din = 8'hF7; tick(); din = 8'hFF; tick();
        din = 8'h7F; tick(); din = 8'hFF; tick();
        checks++;
        if ({dout, gs} !== 4'b100_0) begin
            errors++; $display("FAIL freeze_hold got %b exp %b", {dout, gs}, 4'b1000);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (gs !== 1'b1) begin
            errors++; $display("FAIL freeze_idle got %b exp %b", gs, 1'b1);
        end
        tick();
        checks++;
        if ({dout, gs} !== 4'b000_0) begin
            errors++; $display("FAIL freeze_next got %b exp %b", {dout, gs}, 4'b0000);
        end
    endtask

    task automatic test_collision();
        do_reset();
        ei = 1'b0; tick();
        din = 8'hEF; tick(); din = 8'hFF; tick();
        din = 8'hEF; ack = 1'b1; tick(); din = 8'hFF; ack = 1'b0;
        checks++;
        if ({gs, eo} !== 2'b1_1) begin
            errors++; $display("FAIL collide_idle got %b exp %b", {gs, eo}, 2'b11);
        end
        tick();
        checks++;
        if ({dout, gs} !== 4'b011_0) begin
            errors++; $display("FAIL collide_rereport got %b exp %b", {dout, gs}, 4'b0110);
        end
    endtask

    task automatic test_disable();
        do_reset();
        ei = 1'b0; tick();
        din = 8'hFD; tick(); din = 8'hFF; tick();
        ei = 1'b1; tick();
        checks++;
        if ({dout, gs, eo} !== 5'b111_1_1) begin
            errors++; $display("FAIL disable_out got %b exp %b", {dout, gs, eo}, 5'b11111);
        end
        din = 8'hFE; tick(); din = 8'hFF; tick();
        ei = 1'b0; tick(); tick();
        checks++;
        if ({dout, gs} !== 4'b110_0) begin
            errors++; $display("FAIL disable_first got %b exp %b", {dout, gs}, 4'b1100);
        end
        ack = 1'b1; tick(); ack = 1'b0; tick();
        checks++;
        if ({dout, gs} !== 4'b111_0) begin
            errors++; $display("FAIL disable_second got %b exp %b", {dout, gs}, 4'b1110);
        end
    endtask

    task automatic test_level();
        do_reset();
        lv_ei = 1'b1; lv_din = 16'h0410; tick();
        checks++;
        if ({lv_dout, lv_gs, lv_eo} !== {4'd10, 1'b1, 1'b0}) begin
            errors++; $display("FAIL level_encode got %b exp %b", {lv_dout, lv_gs, lv_eo}, {4'd10, 2'b10});
        end
        lv_din = '0; tick();
        checks++;
        if ({lv_dout, lv_gs, lv_eo} !== {4'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL level_empty got %b exp %b", {lv_dout, lv_gs, lv_eo}, 6'b000001);
        end
        for (int n = 0; n < 100; n++) begin
            int h;
            logic [5:0] exp;
            lv_ei = ($urandom_range(0, 5) != 0);
            lv_din = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom) >> $urandom_range(0, 15);
            lv_ack = 1'($urandom);
            tick();
            h = highest16(lv_req_s);
            exp = (!lv_en_s) ? 6'b0 : (h < 0) ? 6'b000001 : {4'(h), 2'b10};
            checks++;
            if ({lv_dout, lv_gs, lv_eo} !== exp) begin
                errors++; $display("FAIL level_random got %b exp %b", {lv_dout, lv_gs, lv_eo}, exp);
            end
        end
        lv_ack = 1'b0;
    endtask

    task automatic test_random_sticky();
        do_reset();
        ei = 1'b0;
        for (int n = 0; n < 400; n++) begin
            bit       rep;
            bit [2:0] ix;
            logic [4:0] exp;
            din = ($urandom_range(0, 2) == 0) ? (8'($urandom) | 8'($urandom)) : 8'hFF;
            ei = ($urandom_range(0, 9) == 0);
            ack = ($urandom_range(0, 3) == 0);
            tick();
            rep = m_en && m_hold;
            ix = 3'(m_idx);
            exp = {rep ? ~ix : 3'b111, !rep, !(m_en && m_pend == 0 && !rep)};
            checks++;
            if ({dout, gs, eo} !== exp) begin
                errors++; $display("FAIL random_sticky cycle %0d got %b exp %b", n, {dout, gs, eo}, exp);
            end
        end
        ack = 1'b0; ei = 1'b0; din = 8'hFF;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sticky_priority();
        test_hold_freeze();
        test_collision();
        test_disable();
        test_level();
        test_random_sticky();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
